// File: rtl/led_pkg.sv
// Shared constants for the LED chaser: pattern mode codes and FSM state encoding.
package led_pkg;

  localparam logic [1:0] MODE_SHL  = 2'd0;
  localparam logic [1:0] MODE_SHR  = 2'd1;
  localparam logic [1:0] MODE_FILL = 2'd2;
  localparam logic [1:0] MODE_PP   = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_PAUSE = 2'd2
  } state_t;

  // Every mode except FILL keeps exactly one LED lit.
  function automatic logic mode_is_onehot(input logic [1:0] m);
    return m != MODE_FILL;
  endfunction

endpackage

// File: rtl/led_chaser_n_if.sv
// Control/status bundle between the LED chaser and its sequencing logic.
interface led_chaser_n_if #(
  parameter int N     = 8,
  parameter int DIV_W = 16
);
  logic             ss;
  logic [1:0]       mode;
  logic [DIV_W-1:0] div;
  logic [N-1:0]     out;
  logic             step;
  logic             wrap;

  modport master (output ss, mode, div, input out, step, wrap);
  modport slave  (input ss, mode, div, output out, step, wrap);
endinterface

// File: rtl/led_step_div.sv
// Step-rate prescaler: tick marks the clock on which the pattern should advance.
module led_step_div #(
  parameter int DIV_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             clr,
  input  logic [DIV_W-1:0] div,
  output logic             tick
);

  logic [DIV_W-1:0] cnt_reg;

  // >= so that lowering div below the running count fires on the next clock.
  assign tick = en && !clr && (cnt_reg >= div);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_reg <= '0;
    end else if (clr) begin
      cnt_reg <= '0;
    end else if (en) begin
      cnt_reg <= tick ? '0 : cnt_reg + 1'b1;
    end
  end

endmodule

// File: rtl/led_chaser_n.sv
// N-bit LED chaser: run/pause FSM, pattern register and per-mode next-pattern logic.
module led_chaser_n
  import led_pkg::*;
#(
  parameter int N     = 8,
  parameter int DIV_W = 16
) (
  input  logic           clk,
  input  logic           rst,
  led_chaser_n_if.slave  bus
);

  localparam logic [N-1:0] SEED_LO = {{(N-1){1'b0}}, 1'b1};
  localparam logic [N-1:0] SEED_HI = {1'b1, {(N-1){1'b0}}};

  state_t       state_reg;
  logic [N-1:0] pat_reg;
  logic         dir_reg;
  logic [1:0]   mode_reg;
  logic         step_reg;
  logic         wrap_reg;

  logic [N-1:0] shl_pat;
  logic [N-1:0] shr_pat;
  logic [N-1:0] fill_pat;
  logic [N-1:0] pat_next;
  logic         dir_next;
  logic [N-1:0] seed_new;
  logic [N-1:0] seed_cur;
  logic         mode_chg;
  logic         start;
  logic         div_en;
  logic         div_clr;
  logic         tick;

  assign mode_chg = (state_reg != ST_IDLE) && (bus.mode != mode_reg);
  assign start    = (state_reg == ST_IDLE) && bus.ss;
  assign div_en   = (state_reg == ST_RUN) && bus.ss && !mode_chg;
  assign div_clr  = start || mode_chg;

  assign seed_new = (bus.mode == MODE_SHR) ? SEED_HI : SEED_LO;
  assign seed_cur = (mode_reg == MODE_SHR) ? SEED_HI : SEED_LO;

  led_step_div #(.DIV_W(DIV_W)) u_div (
    .clk  (clk),
    .rst  (rst),
    .en   (div_en),
    .clr  (div_clr),
    .div  (bus.div),
    .tick (tick)
  );

  genvar gi;
  generate
    for (gi = 0; gi < N; gi++) begin : g_bit
      assign shl_pat[gi] = pat_reg[(gi + N - 1) % N];
      assign shr_pat[gi] = pat_reg[(gi + 1) % N];
      if (gi == 0) begin : g_lsb
        assign fill_pat[gi] = 1'b1;
      end else begin : g_up
        assign fill_pat[gi] = pat_reg[gi - 1];
      end
    end
  endgenerate

  always_comb begin
    pat_next = pat_reg;
    dir_next = dir_reg;
    case (mode_reg)
      MODE_SHL:  pat_next = shl_pat;
      MODE_SHR:  pat_next = shr_pat;
      MODE_FILL: pat_next = (&pat_reg) ? SEED_LO : fill_pat;
      default: begin
        // Flip direction as the bit lands on an endpoint so it leaves it next step.
        if (dir_reg) begin
          pat_next = shl_pat;
          if (pat_reg[N-2]) dir_next = 1'b0;
        end else begin
          pat_next = shr_pat;
          if (pat_reg[1]) dir_next = 1'b1;
        end
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= ST_IDLE;
      pat_reg   <= '0;
      dir_reg   <= 1'b1;
      mode_reg  <= MODE_SHL;
      step_reg  <= 1'b0;
      wrap_reg  <= 1'b0;
    end else begin
      mode_reg <= bus.mode;
      step_reg <= 1'b0;
      wrap_reg <= 1'b0;
      case (state_reg)
        ST_IDLE: begin
          if (bus.ss) begin
            state_reg <= ST_RUN;
            pat_reg   <= seed_new;
            dir_reg   <= 1'b1;
          end
        end
        default: begin
          if (mode_chg) begin
            pat_reg <= seed_new;
            dir_reg <= 1'b1;
          end else begin
            if (tick) begin
              pat_reg  <= pat_next;
              dir_reg  <= dir_next;
              step_reg <= 1'b1;
              wrap_reg <= (pat_next == seed_cur);
            end
            state_reg <= bus.ss ? ST_RUN : ST_PAUSE;
          end
        end
      endcase
    end
  end

  assign bus.out  = pat_reg;
  assign bus.step = step_reg;
  assign bus.wrap = wrap_reg;

  a_wrap_with_step: assert property (@(posedge clk) disable iff (rst) wrap_reg |-> step_reg);
  a_onehot: assert property (@(posedge clk) disable iff (rst)
    ((state_reg != ST_IDLE) && mode_is_onehot(mode_reg)) |-> $onehot(pat_reg));

endmodule

// File: tb/tb_led_chaser_n.sv
// Randomised and directed checks of led_chaser_n (N=8 and N=2) against a phase-index model.
module tb_led_chaser_n;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  led_chaser_n_if #(.N(8), .DIV_W(16)) bus8 ();
  led_chaser_n_if #(.N(2), .DIV_W(16)) bus2 ();

  led_chaser_n #(.N(8), .DIV_W(16)) dut8 (.clk(clk), .rst(rst), .bus(bus8));
  led_chaser_n #(.N(2), .DIV_W(16)) dut2 (.clk(clk), .rst(rst), .bus(bus2));

  int n_checks = 0;
  int n_errors = 0;

  // Model: a started flag, a pause flag, the active mode and a phase index into its period.
  int m_started[2];
  int m_paused[2];
  int m_mode[2];
  int m_phase[2];
  int m_cnt[2];
  bit e_step[2];
  bit e_wrap[2];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] pat_of(input int md, input int ph, input int n);
    int pos;
    case (md)
      0: return 32'd1 << ph;
      1: return 32'd1 << (n - 1 - ph);
      2: return (32'd2 << ph) - 32'd1;
      default: begin
        pos = (ph < n) ? ph : (2 * n - 2 - ph);
        return 32'd1 << pos;
      end
    endcase
  endfunction

  function automatic int period_of(input int md, input int n);
    return (md == 3) ? (2 * n - 2) : n;
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_started[k] = 0; m_paused[k] = 0; m_mode[k] = 0;
      m_phase[k] = 0; m_cnt[k] = 0; e_step[k] = 0; e_wrap[k] = 0;
    end
  endtask

  task automatic model_edge(input int k, input int n);
    int s, md, dv;
    s = int'(bus8.ss); md = int'(bus8.mode); dv = int'(bus8.div);
    e_step[k] = 0; e_wrap[k] = 0;
    if (m_started[k] == 0) begin
      if (s != 0) begin
        m_started[k] = 1; m_paused[k] = 0; m_mode[k] = md; m_phase[k] = 0; m_cnt[k] = 0;
      end
    end else if (md != m_mode[k]) begin
      m_mode[k] = md; m_phase[k] = 0; m_cnt[k] = 0;
    end else if (m_paused[k] != 0) begin
      if (s != 0) m_paused[k] = 0;
    end else if (s == 0) begin
      m_paused[k] = 1;
    end else if (m_cnt[k] >= dv) begin
      m_phase[k] = (m_phase[k] + 1) % period_of(m_mode[k], n);
      m_cnt[k] = 0;
      e_step[k] = 1;
      e_wrap[k] = (m_phase[k] == 0);
    end else begin
      m_cnt[k]++;
    end
  endtask

  function automatic logic [31:0] exp_out(input int k, input int n);
    return (m_started[k] != 0) ? pat_of(m_mode[k], m_phase[k], n) : 32'd0;
  endfunction

  task automatic compare_all();
    check_eq("out8",  32'(bus8.out),  exp_out(0, 8));
    check_eq("step8", 32'(bus8.step), 32'(e_step[0]));
    check_eq("wrap8", 32'(bus8.wrap), 32'(e_wrap[0]));
    check_eq("out2",  32'(bus2.out),  exp_out(1, 2));
    check_eq("step2", 32'(bus2.step), 32'(e_step[1]));
    check_eq("wrap2", 32'(bus2.wrap), 32'(e_wrap[1]));
  endtask

  task automatic set_inputs(input logic s, input logic [1:0] md, input logic [15:0] dv);
    bus8.ss = s; bus8.mode = md; bus8.div = dv;
    bus2.ss = s; bus2.mode = md; bus2.div = dv;
  endtask

  // One clock: model follows the edge, outputs compared 1 time unit later.
  task automatic cycle();
    @(posedge clk);
    model_edge(0, 8);
    model_edge(1, 2);
    #1;
    compare_all();
  endtask

  task automatic pulse_reset();
    rst = 1'b1;
    #1;
    model_reset();
    check_eq("rst_out8",  32'(bus8.out),  32'd0);
    check_eq("rst_step8", 32'(bus8.step), 32'd0);
    check_eq("rst_wrap8", 32'(bus8.wrap), 32'd0);
    check_eq("rst_out2",  32'(bus2.out),  32'd0);
    #1;
    rst = 1'b0;
  endtask

  logic       r_ss;
  logic [1:0] r_mode;
  logic [15:0] r_div;

  initial begin
    model_reset();
    set_inputs(1'b0, 2'd0, 16'd0);
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    check_eq("init_out8", 32'(bus8.out), 32'd0);
    check_eq("init_step8", 32'(bus8.step), 32'd0);

    // Asynchronous reset while SHL is at 8'h10, then restart.
    set_inputs(1'b1, 2'd0, 16'd0);
    repeat (5) cycle();
    check_eq("pre_rst_out8", 32'(bus8.out), 32'h10);
    pulse_reset();
    cycle();
    check_eq("restart_out8", 32'(bus8.out), 32'h01);

    // SHL div=0 for a full period plus one, checked by the model.
    repeat (9) cycle();

    // Mode switch SHL -> PP while paused at 8'h08.
    pulse_reset();
    set_inputs(1'b1, 2'd0, 16'd0);
    repeat (4) cycle();
    set_inputs(1'b0, 2'd0, 16'd0);
    cycle();
    check_eq("pause_out8", 32'(bus8.out), 32'h08);
    set_inputs(1'b0, 2'd3, 16'd0);
    cycle();
    check_eq("swap_out8", 32'(bus8.out), 32'h01);
    check_eq("swap_step8", 32'(bus8.step), 32'd0);
    repeat (3) cycle();
    check_eq("held_out8", 32'(bus8.out), 32'h01);
    set_inputs(1'b1, 2'd3, 16'd0);
    repeat (16) cycle();

    // SHR div=2 with a 5-clock pause mid-interval.
    pulse_reset();
    set_inputs(1'b1, 2'd1, 16'd2);
    repeat (5) cycle();
    set_inputs(1'b0, 2'd1, 16'd2);
    repeat (5) cycle();
    set_inputs(1'b1, 2'd1, 16'd2);
    repeat (12) cycle();

    // FILL div=0 through the FF -> 01 wrap.
    pulse_reset();
    set_inputs(1'b1, 2'd2, 16'd0);
    repeat (10) cycle();

    // Randomised run, including live div changes and mid-pattern resets.
    r_ss = 1'b1; r_mode = 2'd0; r_div = 16'd0;
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(999) < 3) pulse_reset();
      if (r_ss) begin
        if ($urandom_range(99) < 5) r_ss = 1'b0;
      end else begin
        if ($urandom_range(99) < 25) r_ss = 1'b1;
      end
      if ($urandom_range(99) < 3) r_mode = 2'($urandom_range(3));
      if ($urandom_range(99) < 4) r_div = 16'($urandom_range(4));
      set_inputs(r_ss, r_mode, r_div);
      cycle();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/led_chaser_n.md
# led_chaser_n

Parametrised successor of the 8-LED shifting-light block: drives an N-bit LED bar with four selectable patterns:
- shift-left ring
- shift-right ring
- fill
- ping-pong bounce

A programmable prescaler sets the step rate, and `ss` gives run/pause control. It sits between the board clock domain and the LED output pins. It reports each pattern advance and each completed pattern cycle as single-cycle pulses for sequencing logic.

## Interface
Parameters:
- `N`, default 8: LED count; legal range 2..32.
- `DIV_W`, default 16: prescaler divisor width.

Ports:
- `clk`, input, 1: the block's single clock; all logic is on the rising edge.
- `rst`, input, 1: reset, asynchronous and active-high.
- `ss`, input, 1: start/stop. 1 = run, 0 = pause (pattern frozen).
- `mode`, input, 2: pattern select.
  - 0 = SHL
  - 1 = SHR
  - 2 = FILL
  - 3 = PP
- `div`, input, `DIV_W`: step period minus 1, in clocks. 0 = advance every clock.
- `out`, output, `N`: LED pattern, registered.
- `step`, output, 1: one-cycle pulse on each clock where `out` advances.
- `wrap`, output, 1: one-cycle pulse when an advance returns `out` to the mode seed.

## Operation
States:
- **IDLE**
  - `out` = 0.
  - `ss` = 1 → RUN; load the seed of the current `mode` and clear the prescaler.
- **RUN**
  - The prescaler counts.
  - `ss` = 0 → PAUSE.
- **PAUSE**
  - `out`, the direction bit and the prescaler count are all held.
  - `ss` = 1 → RUN, resuming with the count intact.
- IDLE is reached only through reset.

Mode change (`mode` != registered `mode_q`) in RUN or PAUSE:
- Reload the seed of the new mode, clear the prescaler, set direction to up.
- The state is unchanged.
- `step` and `wrap` stay 0 on that cycle.

Prescaler:
- `cnt` is `DIV_W` bits.
- In RUN, if `cnt >= div` then advance and set `cnt` = 0; otherwise `cnt` = `cnt` + 1.
- The comparison uses `>=` so a live decrease of `div` below `cnt` takes effect on the next clock.

Seeds and per-step advance:
- **SHL**
  - Seed: bit 0.
  - Advance: rotate left; bit N-1 wraps to bit 0.
  - Period: N steps.
- **SHR**
  - Seed: bit N-1.
  - Advance: rotate right; bit 0 wraps to bit N-1.
  - Period: N steps.
- **FILL**
  - Seed: bit 0.
  - Advance: `out` = {`out`[N-2:0], 1}.
  - All-ones advances back to the seed.
  - Period: N steps.
- **PP**
  - Seed: bit 0, direction up.
  - A single lit bit moves toward N-1.
  - On reaching bit N-1 the direction flips and the bit moves down. On reaching bit 0 it flips up.
  - An endpoint is never lit twice consecutively.
  - Period: 2N-2 steps.

Pulse rules:
- `wrap` asserts together with `step` on the advance that produces the seed.
- `wrap` never asserts on a load or reload.
- `out` is exactly one-hot in SHL, SHR and PP, and thermometer-coded in FILL.

## Timing
Reset:
- Asynchronous assertion forces `out` = 0, `step` = 0, `wrap` = 0, `cnt` = 0, direction up, `mode_q` = 0, state IDLE.
- Release is synchronous to `clk`.
- Reset mid-pattern discards all state.

Start:
- `ss` sampled 1 in IDLE at edge k gives `out` = seed after edge k.
- The first advance happens at edge k+`div`+1.

Advances:
- Subsequent advances are every `div`+1 clocks while in RUN.
- `step` is high in the cycle after the edge that updated `out`. Both are registered on the same edge.

Pause and resume:
- Pause at edge p: no advance at or after p.
- Resume: the remaining count continues, so the total RUN clocks between advances is still `div`+1.

Simultaneous events:
- Mode change and advance on the same edge: the reload wins, with no `step`.
- `ss` falling and the terminal count on the same edge: PAUSE wins, with no advance.

## Structure
Shared package `led_pkg` holds:
- Mode constants `MODE_SHL`, `MODE_SHR`, `MODE_FILL`, `MODE_PP`.
- The state encoding `ST_IDLE`, `ST_RUN`, `ST_PAUSE`.

Sub-module `led_step_div` (parameter `DIV_W`):
- Inputs: `clk`, `rst`, `en`, `clr`, `div`.
- Output: `tick`.
- Holds the prescaler.

The top level holds the FSM, pattern register, direction bit and the seed/next-pattern logic.

## Test plan
All scenarios use N=8 unless noted.
- Reset while running SHL at `out`=8'h10: `out`=0, `step`=0 and `wrap`=0 immediately, without a clock edge. Then `ss`=1 gives `out`=8'h01.
- SHL, `div`=0, `ss`=1 for 9 clocks: `out` = 01, 02, 04 … 80, 01. `step` is high every cycle; `wrap` is high only on the return to 01.
- SHR, `div`=2: `out` = 80, 40, 20 …, changing every 3 clocks. `ss`=0 for 5 clocks mid-period, then resume: the interval spanning the pause contains exactly 3 RUN clocks.
- FILL, `div`=0: `out` = 01, 03, 07 … FF, 01. `wrap` asserts on the FF→01 advance.
- PP, `div`=0: `out` = 01, 02 … 80, 40 … 02, 01, a 14-step period. `wrap` asserts on the 02→01 advance. With N=2: 1, 2, 1, 2.
- Mode switch from SHL to PP while in PAUSE at `out`=08: the next clock gives `out`=01 with no `step`, state stays PAUSE, and there are no advances until `ss`=1.
